mult_seq_32b: RTL and testbench

- Multi-cycle 32x32 unsigned shift-add multiplier for the ALU's MUL path.
- Each cycle forms a partial product by bitwise AND of the multiplicand with the current multiplier bit replicated 32 times.
- That partial product feeds a 33-bit accumulate; the product register then shifts right.
- Sits beside the bitwise units; the ALU result mux consumes its 64-bit product, with a start/busy/done handshake to the ALU controller.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_and_unit.sv | 17 +
 rtl/mult_ctrl_fsm.sv | 84 ++++++++
 rtl/mult_seq_32b.sv | 98 +++++++++
 tb/tb_mult_seq_32b.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states, word widths and the MUL opcode
// the ALU controller decodes to pulse the multiplier's start.
package alu_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_OP_MUL = 4'hA;

endpackage

// File: rtl/alu_and_unit.sv
// Bitwise AND unit shared by the ALU logic path and the multiplier partial product.
module alu_and_unit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y_o[gi] = a_i[gi] & b_i[gi];
    end
  endgenerate

endmodule

// File: rtl/mult_ctrl_fsm.sv
// Sequencer for the shift-add multiplier: IDLE/CALC/DONE, iteration counter,
// busy/done handshake and datapath enables. MULT_EARLY_TERM_EN adds early exit.
module mult_ctrl_fsm
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
`ifdef MULT_EARLY_TERM_EN
  input  logic             early_i,
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             load_o,
  output logic             shift_o,
  output logic             capture_o
);

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_iter;

`ifdef MULT_EARLY_TERM_EN
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || early_i;
  assign cnt_o     = cnt_q;
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    load_o    = 1'b0;
    shift_o   = 1'b0;
    capture_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        busy_o  = 1'b1;
        shift_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_iter) begin
          capture_o = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o = 1'b1;
        // A start here is accepted immediately for back-to-back products.
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mult_seq_32b.sv
// 32x32 unsigned shift-add multiplier with start/busy/done handshake.
// Optional early termination on exhausted multiplier bits: MULT_EARLY_TERM_EN.
module mult_seq_32b
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum33;
  logic [2*WIDTH-1:0] p_shift;
  logic [2*WIDTH-1:0] p_final;
  logic               load_en, shift_en, capture_en;

  alu_and_unit #(.WIDTH(WIDTH)) u_pp_and (
    .a_i (mcand_q),
    .b_i ({WIDTH{p_q[0]}}),
    .y_o (pp)
  );

  // The add carry lands in P's MSB, so no bit of the product is lost.
  assign sum33   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};
  assign p_shift = {sum33, p_q[WIDTH-1:1]};

`ifdef MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_mask;
  logic [CNT_W-1:0] rem_shift;
  logic             early;

  // After this cycle's shift, the low WIDTH-1-cnt bits are unprocessed multiplier bits.
  assign rem_mask  = {WIDTH{1'b1}} >> ({1'b0, cnt} + (CNT_W + 1)'(1));
  assign rem_shift = CNT_W'(WIDTH - 1) - cnt;
  assign early     = ((p_shift[WIDTH-1:0] & rem_mask) == '0);
  assign p_final   = early ? (p_shift >> rem_shift) : p_shift;

  mult_ctrl_fsm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start),
    .early_i   (early),
    .cnt_o     (cnt),
    .busy_o    (busy),
    .done_o    (done),
    .load_o    (load_en),
    .shift_o   (shift_en),
    .capture_o (capture_en)
  );
`else
  assign p_final = p_shift;

  mult_ctrl_fsm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .load_o    (load_en),
    .shift_o   (shift_en),
    .capture_o (capture_en)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      p_q       <= '0;
      product_q <= '0;
    end else begin
      if (load_en) begin
        mcand_q <= a;
        p_q     <= {{WIDTH{1'b0}}, b};
      end else if (shift_en) begin
        p_q <= p_final;
      end
      // Only the finished value is published; intermediate P never reaches the port.
      if (capture_en) begin
        product_q <= p_final;
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_mult_seq_32b.sv
// Self-checking bench for mult_seq_32b: vector table, handshake corner cases,
// and randomized operands against a plain-arithmetic reference.
module tb_mult_seq_32b;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int n_cmp  = 0;
  int n_fail = 0;

  mult_seq_32b dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] exp_p;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp_v);
    end
  endtask

  function automatic int exp_calc_cycles(input logic [31:0] mb);
`ifdef MULT_EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) if (mb[i]) msb = i;
    return (msb < 0) ? 1 : msb + 1;
`else
    return (mb == mb) ? 32 : 32;
`endif
  endfunction

  // Called at a negedge; start is sampled at the next posedge (edge 0).
  // Returns the number of edges until done is seen and the busy-cycle count.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input bit inject,
                       output int lat, output int busy_cnt, output logic [63:0] prod);
    start = 1'b1; a = ta; b = tb_v;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      // Stray starts and operand churn mid-calculation must be ignored.
      if (inject) begin
        start = (lat == 5 || lat == 6);
        a = $urandom; b = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    prod = product;
    if (!done) chk("done_timeout", 64'(lat), 64'(exp_calc_cycles(tb_v) + 1));
    $display("op a=0x%08h b=0x%08h product=0x%016h latency=%0d busy=%0d", ta, tb_v, prod, lat, busy_cnt);
  endtask

  task automatic run_checked(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic [63:0] exp_p, input bit inject);
    int lat, bc;
    logic [63:0] p;
    do_op(ta, tb_v, inject, lat, bc, p);
    chk({tag, "_product"}, p, exp_p);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_calc_cycles(tb_v) + 1));
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_calc_cycles(tb_v)));
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
  endtask

  vec_t vecs[7];
  int   lat, bc;
  logic [63:0] p, held;
  logic [31:0] ra, rb;

  initial begin
    vecs[0] = '{32'd7,        32'd6,        64'h0000_0000_0000_002A};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,        32'd0,        64'h0};
    vecs[3] = '{32'd1,        32'hFFFFFFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[4] = '{32'h12345678, 32'd5,        64'h0000_0000_5B05_B058};
    vecs[5] = '{32'hDEADBEEF, 32'h80000000, 64'h6F56_DF77_8000_0000};
    vecs[6] = '{32'hFFFFFFFF, 32'd0,        64'h0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_checked($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp_p, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d_product_held", i), product, vecs[i].exp_p);
    end

    // Back-to-back: second start issued in the DONE cycle, stray starts during CALC.
    run_checked("b2b_first", 32'd3, 32'd5, 64'd15, 1'b1);
    chk("b2b_first_done", 64'(done), 64'd1);
    run_checked("b2b_second", 32'h10000, 32'h10000, 64'h0000_0001_0000_0000, 1'b1);
    @(negedge clk);
    chk("b2b_idle_done", 64'(done), 64'd0);

    // Reset during CALC discards the partial result and clears the output.
    start = 1'b1; a = 32'hABCD; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", product, 64'd0);
    $display("op reset asserted at CALC cycle 10");
    run_checked("after_rst", 32'd2, 32'd9, 64'd18, 1'b0);

    // Product hold with operands changing and no start.
    held = product;
    @(negedge clk);
    for (int c = 0; c < 50; c++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
      chk("hold_product", product, 64'd18);
      chk("hold_busy", 64'(busy), 64'd0);
      chk("hold_done", 64'(done), 64'd0);
    end
    $display("op hold 50 cycles product=0x%016h", held);

    for (int r = 0; r < 30; r++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (r % 5 == 0) ra = ra >> $urandom_range(0, 31);
      run_checked($sformatf("rand%0d", r), ra, rb, 64'(ra) * 64'(rb), 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
